psum_recirc_sched: RTL
======================

Name: psum_recirc_sched

Overview:
- Scheduler that time-shares one `delay` line as a recirculating partial-sum store for channel accumulation in the conv pipeline.
- Each tile holds up to DELAY_NB pixels. Each pixel owns a fixed slot of the loop.
- For every pixel, incoming psums from successive input channels are added to the value returning from the loop. After the last channel the finished sum goes out on a valid/ready stream.
- Sits between the PE-array psum output and the output writer.

Parameters:
- DELAY_NB, 27, loop length in cycles; also the maximum number of pixels per tile.
- SUM_BW, 16, psum width (signed).
- CH_BW, 8, width of the channel count.
- TILE_BW, 16, width of the tile count.
- PX_BW, $clog2(DELAY_NB+1), localparam, width of the pixel count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled in IDLE only
- i_num_px  in  PX_BW  pixels per tile; values above DELAY_NB are clamped to DELAY_NB
- i_num_ch  in  CH_BW  input channels to accumulate
- i_num_tile  in  TILE_BW  tiles per job
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse at job end
- s_valid  in  1  input psum valid
- s_ready  out  1  input psum accepted this cycle
- s_psum  in  SUM_BW signed  input psum
- m_valid  out  1  output sum valid
- m_ready  in  1  downstream ready
- m_psum  out  SUM_BW signed  accumulated sum

Behaviour:
- Reset (asynchronous): state IDLE. All counters 0. o_busy=0, o_done=0, s_ready=0, m_valid=0, m_psum=0. The internal delay is cleared by its own reset.
- Loop timing: a value written at cycle t reappears at the delay output at cycle t+DELAY_NB.
- slot_cnt: free-running modulo DELAY_NB counter. Zeroed on entry to RUN.
- State IDLE:
  - i_start=1 latches the config.
  - If any count is 0, o_done pulses the next cycle and the block stays in IDLE.
  - Otherwise it moves to RUN with slot_cnt=0, px_idx=0, ch_idx=0, tile_idx=0.
- State RUN, ready condition: s_ready = (slot_cnt==px_idx) && (ch_idx!=num_ch-1 || !m_valid || m_ready). Pixel p of every channel pass therefore enters only at slot p.
- State RUN, on accept (s_valid && s_ready):
  - Loop input = s_psum when ch_idx==0, else s_psum + dly_out.
  - If ch_idx==num_ch-1: m_psum = s_psum + dly_out (for num_ch==1, m_psum = s_psum), m_valid is set, and the loop input is 0.
- State RUN, no accept: loop input = dly_out (recirculate unchanged). Slots ≥ num_px also recirculate.
- State RUN, counter advance on accept:
  - px_idx increments.
  - At num_px-1, px_idx wraps to 0 and ch_idx increments.
  - At num_ch-1, ch_idx wraps to 0 and tile_idx increments.
  - After the last tile's last pixel the block moves to DRAIN.
- Missed slot: if s_valid is low or the output is blocked at the matching slot, the pixel waits a full DELAY_NB cycles for its next slot. Alignment is never lost.
- State DRAIN: waits for m_valid=0. The next cycle it pulses o_done, then returns to IDLE.
- IDLE loop input: 0.
- Output handshake: m_valid clears on m_ready unless a new sum loads in the same cycle; a same-cycle load keeps m_valid=1 with the new data. m_psum holds while m_valid && !m_ready.
- Arithmetic: SUM_BW two's-complement wrap, no saturation.
- Latency with an always-valid source and m_ready=1:
  - Pixel p of channel c is accepted at RUN-entry + c·DELAY_NB + p.
  - m_valid rises one cycle after the last-channel accept.
  - Throughput is num_px sums per DELAY_NB·num_ch cycles per tile.
- i_start during RUN/DRAIN: ignored.
- Reset mid-job: job aborted, all state cleared, no o_done.

Decomposition:
- Shared conv package holds the SUM_BW default and the state encoding (IDLE, RUN, DRAIN).
- Sub-module: one instance of the existing `delay` module (DELAY_NB, SUM_BW), fed by the loop-input mux.
- Counters and FSM are inline.

Test Plan (DELAY_NB=4 override):
- num_px=4, ch=3, tile=1, psum=ch+1 every cycle, m_ready=1 -> four outputs of 6 at RUN+9..12; o_done once.
- num_px=2, ch=2, psums 5/-3 then 10/4 -> outputs 15, 1; slots 2–3 never accept.
- ch=2, s_valid low at pixel 1's first-channel slot -> that pixel is accepted 4 cycles later; sums still correct.
- m_ready=0 for 10 cycles at the last channel -> s_ready stays low at last-channel slots; m_psum is stable; no loss; resumes on the next matching slot.
- num_ch=0 -> o_done one cycle after i_start, no m_valid.
- rst_n low mid-RUN, then a new job (ch=1, psum=7) -> outputs exactly 7; no stale loop data.

Source files
------------

// File: rtl/psum_recirc_sched_pkg.sv
// psum_recirc_sched_pkg: shared psum width default and scheduler FSM encoding
package psum_recirc_sched_pkg;
  localparam int SUM_BW_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/psum_recirc_sched_if.sv
// psum_recirc_sched_if: valid/ready psum stream between PE array, scheduler and output writer
interface psum_recirc_sched_if import psum_recirc_sched_pkg::*; #(
  parameter int SUM_BW = SUM_BW_DEF
);
  logic valid;
  logic ready;
  logic signed [SUM_BW-1:0] psum;
  modport master (output valid, psum, input ready);
  modport slave (input valid, psum, output ready);
endinterface

// File: rtl/psum_recirc_sched_delay.sv
// delay: fixed-length shift line; a value written at cycle t appears on q_o at t+DELAY_NB
module delay #(
  parameter int DELAY_NB = 27,
  parameter int SUM_BW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signed [SUM_BW-1:0] d_i,
  output logic signed [SUM_BW-1:0] q_o
);
  logic signed [SUM_BW-1:0] line_q [DELAY_NB];
  // advance the line one stage per cycle; reset empties every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY_NB; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= d_i;
      for (int i = 1; i < DELAY_NB; i++) line_q[i] <= line_q[i-1];
    end
  end
  assign q_o = line_q[DELAY_NB-1];
endmodule

// File: rtl/psum_recirc_sched.sv
// psum_recirc_sched: accumulates per-pixel psums over channels in a recirculating delay loop
module psum_recirc_sched import psum_recirc_sched_pkg::*; #(
  parameter int DELAY_NB = 27,
  parameter int SUM_BW = SUM_BW_DEF,
  parameter int CH_BW = 8,
  parameter int TILE_BW = 16,
  localparam int PX_BW = $clog2(DELAY_NB+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [PX_BW-1:0]   i_num_px,
  input  logic [CH_BW-1:0]   i_num_ch,
  input  logic [TILE_BW-1:0] i_num_tile,
  output logic               o_busy,
  output logic               o_done,
  psum_recirc_sched_if.slave  s,
  psum_recirc_sched_if.master m
);
  localparam logic [PX_BW-1:0] PX_LIM = PX_BW'(DELAY_NB);
  state_e state_q;
  logic [PX_BW-1:0] slot_q, px_q, num_px_q;
  logic [CH_BW-1:0] ch_q, num_ch_q;
  logic [TILE_BW-1:0] tile_q, num_tile_q;
  logic m_valid_q, done_q;
  logic signed [SUM_BW-1:0] m_psum_q, dly_out, loop_d, sum;
  logic last_px, last_ch, last_tile, accept, load;
  assign sum = s.psum + dly_out;
  assign last_px = px_q == num_px_q - PX_BW'(1);
  assign last_ch = ch_q == num_ch_q - CH_BW'(1);
  assign last_tile = tile_q == num_tile_q - TILE_BW'(1);
  assign s.ready = state_q == RUN && slot_q == px_q && (!last_ch || !m_valid_q || m.ready);
  assign accept = s.valid && s.ready;
  assign load = accept && last_ch;
  assign loop_d = state_q != RUN ? '0 : !accept ? dly_out : last_ch ? '0 : ch_q == '0 ? s.psum : sum;
  assign o_busy = state_q != IDLE;
  assign o_done = done_q;
  assign m.valid = m_valid_q;
  assign m.psum = m_psum_q;
  delay #(.DELAY_NB(DELAY_NB), .SUM_BW(SUM_BW)) u_loop (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (loop_d),
    .q_o  (dly_out)
  );
  // FSM, slot/pixel/channel/tile counters and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q <= '0;
      px_q <= '0;
      ch_q <= '0;
      tile_q <= '0;
      num_px_q <= '0;
      num_ch_q <= '0;
      num_tile_q <= '0;
      m_valid_q <= 1'b0;
      m_psum_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      slot_q <= slot_q == PX_BW'(DELAY_NB-1) ? '0 : slot_q + PX_BW'(1);
      if (load) begin
        m_valid_q <= 1'b1;
        m_psum_q <= ch_q == '0 ? s.psum : sum;
      end else if (m.ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (i_start) begin
          num_px_q <= i_num_px > PX_LIM ? PX_LIM : i_num_px;
          num_ch_q <= i_num_ch;
          num_tile_q <= i_num_tile;
          slot_q <= '0;
          px_q <= '0;
          ch_q <= '0;
          tile_q <= '0;
          if (i_num_px == '0 || i_num_ch == '0 || i_num_tile == '0) done_q <= 1'b1;
          else state_q <= RUN;
        end
        RUN: if (accept) begin
          px_q <= last_px ? '0 : px_q + PX_BW'(1);
          if (last_px) begin
            ch_q <= last_ch ? '0 : ch_q + CH_BW'(1);
            if (last_ch) begin
              tile_q <= last_tile ? '0 : tile_q + TILE_BW'(1);
              if (last_tile) state_q <= DRAIN;
            end
          end
        end
        DRAIN: if (!m_valid_q) begin
          done_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
